// File: rtl/xmt_arbiter.sv
// ============================================================================
// Module   : xmt_arbiter
// Purpose  : Round-robin arbiter sharing one UART Sender among N byte clients,
//            driving the XMT_REQ/XMT_ACK four-phase handshake with timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xmt_arbiter #(
    parameter int N       = 4,
    parameter int IDX_W   = $clog2(N),
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   data,
    output logic [N-1:0]     done,
    output logic [N-1:0]     err,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id,
    output logic             XMT_REQ,
    output logic [7:0]       XMT_DATA,
    input  logic             XMT_ACK
);

    localparam int             CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ACK = 3'd1,
        S_WAIT_REL = 3'd2,
        S_DONE     = 3'd3,
        S_ABORT    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gid;
    logic [7:0]         r_data;
    logic               r_req;
    logic               r_busy;
    logic [N-1:0]       r_done;
    logic [N-1:0]       r_err;

    logic [7:0]         w_bytes [N];
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_idx;
    logic [N-1:0]       w_oh;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bytes
            assign w_bytes[gi] = data[8*gi +: 8];
        end
    endgenerate

    // First requester at or after the rr pointer, wrapping modulo N.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_oh = {{(N-1){1'b0}}, 1'b1} << r_gid;

    // Handshake edges are checked before the timeout so they win a tie.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any && !XMT_ACK) w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (XMT_ACK)                 w_next = S_WAIT_REL;
                else if (r_cnt == c_CNT_MAX) w_next = S_ABORT;
            end
            S_WAIT_REL: begin
                if (!XMT_ACK)                w_next = S_DONE;
                else if (r_cnt == c_CNT_MAX) w_next = S_ABORT;
            end
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_data  <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT_ACK || r_state == S_WAIT_REL)
                         && r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == S_IDLE && w_next == S_WAIT_ACK) begin
                r_gid  <= w_win;
                r_data <= w_bytes[w_win];
            end

            if (r_state == S_DONE || r_state == S_ABORT) begin
                if (r_gid == IDX_W'(N - 1)) r_ptr <= '0;
                else                        r_ptr <= r_gid + IDX_W'(1);
            end

            // Outputs are registered from the next state so they line up with it.
            r_req  <= (w_next == S_WAIT_ACK);
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE)  ? w_oh : '0;
            r_err  <= (w_next == S_ABORT) ? w_oh : '0;
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign busy     = r_busy;
    assign grant_id = r_gid;
    assign XMT_REQ  = r_req;
    assign XMT_DATA = r_data;

endmodule

`default_nettype wire
